// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: IF/ID register, control decode, bypassed 2R1W
// register file and ID/EX register with stall, flush and load-use bubbles.
`timescale 1ns/1ps
module decode_stage_pipelined #(
   parameter int DATA_W     = 32,
   parameter int PC_W       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_valid,
   output logic                  if_ready,
   input  logic [PC_W-1:0]       if_pc,
   input  logic [31:0]           if_instr,
   input  logic                  flush,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  ex_ready,
   output logic                  ex_valid,
   output logic [PC_W-1:0]       ex_pc,
   output logic [DATA_W-1:0]     ex_rd1,
   output logic [DATA_W-1:0]     ex_rd2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_reg_dst,
   output logic                  ex_branch,
   output logic                  ex_mem_read,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_write,
   output logic                  ex_alu_src,
   output logic                  ex_reg_write,
   output logic [1:0]            ex_alu_op
);
   localparam int NUM_REGS = 2**REG_ADDR_W;
   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_BEQ = 6'h04;

   logic                  r_id_valid;
   logic [PC_W-1:0]       r_id_pc;
   logic [31:0]           r_id_instr;
   logic [DATA_W-1:0]     r_rf [NUM_REGS];

   logic                  r_ex_valid;
   logic [PC_W-1:0]       r_ex_pc;
   logic [DATA_W-1:0]     r_ex_rd1;
   logic [DATA_W-1:0]     r_ex_rd2;
   logic [DATA_W-1:0]     r_ex_imm;
   logic [REG_ADDR_W-1:0] r_ex_rs;
   logic [REG_ADDR_W-1:0] r_ex_rt;
   logic [REG_ADDR_W-1:0] r_ex_rd;
   logic                  r_ex_reg_dst;
   logic                  r_ex_branch;
   logic                  r_ex_mem_read;
   logic                  r_ex_mem_to_reg;
   logic                  r_ex_mem_write;
   logic                  r_ex_alu_src;
   logic                  r_ex_reg_write;
   logic [1:0]            r_ex_alu_op;

   logic [5:0]            w_op;
   logic [REG_ADDR_W-1:0] w_rs;
   logic [REG_ADDR_W-1:0] w_rt;
   logic [REG_ADDR_W-1:0] w_rd;
   logic                  w_is_r;
   logic                  w_is_lw;
   logic                  w_is_sw;
   logic                  w_is_beq;
   logic                  w_uses_rt;
   logic                  w_hazard;
   logic                  w_ex_go;
   logic                  w_advance;
   logic                  w_if_ready;
   logic [DATA_W-1:0]     w_rd1;
   logic [DATA_W-1:0]     w_rd2;
   logic [DATA_W-1:0]     w_imm;
   logic                  w_reg_dst;
   logic                  w_branch;
   logic                  w_mem_read;
   logic                  w_mem_to_reg;
   logic                  w_mem_write;
   logic                  w_alu_src;
   logic                  w_reg_write;
   logic [1:0]            w_alu_op;

   assign w_op     = r_id_instr[31:26];
   assign w_rs     = r_id_instr[21 +: REG_ADDR_W];
   assign w_rt     = r_id_instr[16 +: REG_ADDR_W];
   assign w_rd     = r_id_instr[11 +: REG_ADDR_W];
   assign w_is_r   = (w_op == OP_R);
   assign w_is_lw  = (w_op == OP_LW);
   assign w_is_sw  = (w_op == OP_SW);
   assign w_is_beq = (w_op == OP_BEQ);
   assign w_uses_rt = w_is_r | w_is_sw | w_is_beq;

   // A load in EX cannot forward yet, so a dependent instr waits a cycle
   assign w_hazard = r_ex_valid && r_ex_mem_read && (r_ex_rt != '0) &&
                     ((r_ex_rt == w_rs) || (w_uses_rt && (r_ex_rt == w_rt)));

   assign w_ex_go    = !r_ex_valid || ex_ready;
   assign w_advance  = r_id_valid && !w_hazard && w_ex_go;
   assign w_if_ready = !rst && !flush && (!r_id_valid || w_advance);

   assign w_rd1 = (w_rs == '0) ? '0 :
                  (wb_we && (wb_addr == w_rs)) ? wb_data : r_rf[w_rs];
   assign w_rd2 = (w_rt == '0) ? '0 :
                  (wb_we && (wb_addr == w_rt)) ? wb_data : r_rf[w_rt];
   assign w_imm = DATA_W'($signed(r_id_instr[15:0]));

   always_comb begin
      w_reg_dst    = 1'b0;
      w_branch     = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_to_reg = 1'b0;
      w_mem_write  = 1'b0;
      w_alu_src    = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_op     = 2'b00;
      unique case (1'b1)
         w_is_r: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
            w_alu_op    = 2'b10;
         end
         w_is_lw: begin
            w_alu_src    = 1'b1;
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
            w_mem_read   = 1'b1;
         end
         w_is_sw: begin
            w_alu_src   = 1'b1;
            w_mem_write = 1'b1;
         end
         w_is_beq: begin
            w_branch = 1'b1;
            w_alu_op = 2'b01;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
      end else if (wb_we && (wb_addr != '0)) begin
         r_rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_id_valid <= 1'b0;
         r_id_pc    <= '0;
         r_id_instr <= '0;
      end else if (flush) begin
         r_id_valid <= 1'b0;
      end else if (if_valid && w_if_ready) begin
         r_id_valid <= 1'b1;
         r_id_pc    <= if_pc;
         r_id_instr <= if_instr;
      end else if (w_advance) begin
         r_id_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid      <= 1'b0;
         r_ex_pc         <= '0;
         r_ex_rd1        <= '0;
         r_ex_rd2        <= '0;
         r_ex_imm        <= '0;
         r_ex_rs         <= '0;
         r_ex_rt         <= '0;
         r_ex_rd         <= '0;
         r_ex_reg_dst    <= 1'b0;
         r_ex_branch     <= 1'b0;
         r_ex_mem_read   <= 1'b0;
         r_ex_mem_to_reg <= 1'b0;
         r_ex_mem_write  <= 1'b0;
         r_ex_alu_src    <= 1'b0;
         r_ex_reg_write  <= 1'b0;
         r_ex_alu_op     <= 2'b00;
      end else if (flush || (w_ex_go && !w_advance)) begin
         r_ex_valid      <= 1'b0;
         r_ex_reg_dst    <= 1'b0;
         r_ex_branch     <= 1'b0;
         r_ex_mem_read   <= 1'b0;
         r_ex_mem_to_reg <= 1'b0;
         r_ex_mem_write  <= 1'b0;
         r_ex_alu_src    <= 1'b0;
         r_ex_reg_write  <= 1'b0;
         r_ex_alu_op     <= 2'b00;
      end else if (w_advance) begin
         r_ex_valid      <= 1'b1;
         r_ex_pc         <= r_id_pc;
         r_ex_rd1        <= w_rd1;
         r_ex_rd2        <= w_rd2;
         r_ex_imm        <= w_imm;
         r_ex_rs         <= w_rs;
         r_ex_rt         <= w_rt;
         r_ex_rd         <= w_rd;
         r_ex_reg_dst    <= w_reg_dst;
         r_ex_branch     <= w_branch;
         r_ex_mem_read   <= w_mem_read;
         r_ex_mem_to_reg <= w_mem_to_reg;
         r_ex_mem_write  <= w_mem_write;
         r_ex_alu_src    <= w_alu_src;
         r_ex_reg_write  <= w_reg_write;
         r_ex_alu_op     <= w_alu_op;
      end
   end

   assign if_ready      = w_if_ready;
   assign ex_valid      = r_ex_valid;
   assign ex_pc         = r_ex_pc;
   assign ex_rd1        = r_ex_rd1;
   assign ex_rd2        = r_ex_rd2;
   assign ex_imm        = r_ex_imm;
   assign ex_rs         = r_ex_rs;
   assign ex_rt         = r_ex_rt;
   assign ex_rd         = r_ex_rd;
   assign ex_reg_dst    = r_ex_reg_dst;
   assign ex_branch     = r_ex_branch;
   assign ex_mem_read   = r_ex_mem_read;
   assign ex_mem_to_reg = r_ex_mem_to_reg;
   assign ex_mem_write  = r_ex_mem_write;
   assign ex_alu_src    = r_ex_alu_src;
   assign ex_reg_write  = r_ex_reg_write;
   assign ex_alu_op     = r_ex_alu_op;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: directed instructions,
// expected ID/EX records queued at issue and checked on EX handoff.
`timescale 1ns/1ps
module tb_decode_stage_pipelined;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0;
   logic        if_ready;
   logic [31:0] if_pc = '0;
   logic [31:0] if_instr = '0;
   logic        flush = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        ex_ready = 1'b1;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg;
   logic        ex_mem_write, ex_alu_src, ex_reg_write;
   logic [1:0]  ex_alu_op;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [6:0]  ctl;
      logic [1:0]  op;
   } rec_t;
   typedef enum {K_R, K_LW, K_SW, K_BEQ, K_OT} kind_t;

   rec_t q[$];
   int checks = 0;
   int errors = 0;

   decode_stage_pipelined dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
      .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
      .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op)
   );

   always #5 clk = ~clk;

   // ctl = {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write}
   function automatic rec_t mk(input kind_t k, input logic [31:0] pc,
                               input logic [31:0] ins, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] imm);
      rec_t r;
      r.pc  = pc;
      r.rd1 = rd1;
      r.rd2 = rd2;
      r.imm = imm;
      r.rs  = ins[25:21];
      r.rt  = ins[20:16];
      r.rd  = ins[15:11];
      case (k)
         K_R:     begin r.ctl = 7'b1000001; r.op = 2'b10; end
         K_LW:    begin r.ctl = 7'b0011011; r.op = 2'b00; end
         K_SW:    begin r.ctl = 7'b0000110; r.op = 2'b00; end
         K_BEQ:   begin r.ctl = 7'b0100000; r.op = 2'b01; end
         default: begin r.ctl = 7'b0000000; r.op = 2'b00; end
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      rec_t a, e;
      if (!rst && ex_valid && ex_ready) begin
         a = {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
              ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
              ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op};
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL ex_unexpected got %h exp none", a);
         end else begin
            e = q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL ex_rec got %h exp %h", a, e);
            end
         end
      end
   end

   task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                       input bit push, input rec_t e);
      int n = 0;
      if_valid = 1'b1;
      if_instr = ins;
      if_pc    = pc;
      @(negedge clk);
      while (!if_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!if_ready) chk("send_timeout", 32'(if_ready), 32'd1);
      @(posedge clk);
      #1;
      if_valid = 1'b0;
      if (push) q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ins;
      logic [4:0]  kk;
      rec_t none;
      none = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_reg_write", 32'(ex_reg_write), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_if_ready", 32'(if_ready), 32'd1);
      @(posedge clk);
      #1;

      for (int k = 1; k < 32; k++) begin
         kk  = k[4:0];
         ins = {6'h00, kk, kk, 5'd0, 5'd0, 6'h20};
         send(ins, 32'(k * 4), 1'b1, mk(K_R, 32'(k * 4), ins, 0, 0, 32'h20));
      end
      idle(2);

      wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
      idle(1);
      wb_addr = 5'd2; wb_data = 32'd7;
      idle(1);
      wb_we = 1'b0;

      send(32'h00221820, 32'h100, 1'b1,
           mk(K_R, 32'h100, 32'h00221820, 5, 7, 32'h1820));

      send(32'h8C040000, 32'h104, 1'b1,
           mk(K_LW, 32'h104, 32'h8C040000, 0, 0, 0));
      send(32'h00842820, 32'h108, 1'b1,
           mk(K_R, 32'h108, 32'h00842820, 0, 0, 32'h2820));
      @(negedge clk);
      chk("lu_if_ready", 32'(if_ready), 32'd0);
      chk("lu_ex_lw", 32'(ex_rt), 32'd4);
      @(negedge clk);
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      @(negedge clk);
      chk("lu_add_issue", 32'(ex_valid), 32'd1);
      chk("lu_add_rd", 32'(ex_rd), 32'd5);
      @(posedge clk);
      #1;

      send(32'h00C03820, 32'h10C, 1'b1,
           mk(K_R, 32'h10C, 32'h00C03820, 32'hDEAD, 0, 32'h3820));
      wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'hDEAD;
      idle(1);
      wb_we = 1'b0;
      send(32'h00003820, 32'h110, 1'b1,
           mk(K_R, 32'h110, 32'h00003820, 0, 0, 32'h3820));
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hBEEF;
      idle(1);
      wb_we = 1'b0;
      send(32'h00C14020, 32'h114, 1'b1,
           mk(K_R, 32'h114, 32'h00C14020, 32'hDEAD, 5, 32'h4020));

      send(32'h8C29FFF0, 32'h118, 1'b1,
           mk(K_LW, 32'h118, 32'h8C29FFF0, 5, 0, 32'hFFFFFFF0));
      send(32'hAC220004, 32'h11C, 1'b1,
           mk(K_SW, 32'h11C, 32'hAC220004, 5, 7, 32'h4));
      send(32'h1022FFFF, 32'h120, 1'b1,
           mk(K_BEQ, 32'h120, 32'h1022FFFF, 5, 7, 32'hFFFFFFFF));
      send(32'h20230010, 32'h124, 1'b1,
           mk(K_OT, 32'h124, 32'h20230010, 5, 0, 32'h10));
      idle(3);

      ex_ready = 1'b0;
      send(32'h00221820, 32'h200, 1'b0, none);
      send(32'h00842820, 32'h204, 1'b0, none);
      repeat (4) begin
         @(negedge clk);
         chk("bp_ex_valid", 32'(ex_valid), 32'd1);
         chk("bp_ex_pc", ex_pc, 32'h200);
         chk("bp_ex_rd1", ex_rd1, 32'd5);
         chk("bp_if_ready", 32'(if_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      flush = 1'b1;
      if_valid = 1'b1; if_instr = 32'h00003820; if_pc = 32'h300;
      @(negedge clk);
      chk("fl_if_ready", 32'(if_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      if_valid = 1'b0;
      @(negedge clk);
      chk("fl_ex_valid", 32'(ex_valid), 32'd0);
      chk("fl_ex_reg_write", 32'(ex_reg_write), 32'd0);
      #1;
      ex_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("fl_id_killed", 32'(ex_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(32'h00221820, 32'h304, 1'b1,
           mk(K_R, 32'h304, 32'h00221820, 5, 7, 32'h1820));
      idle(3);

      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
